// File: rtl/phase_scheduler.sv
// Sequenced traffic-phase scheduler: grants one direction at a time through
// green, yellow and all-red clearance, with min/max green and starvation control.
module phase_scheduler #(
  parameter int unsigned MIN_GREEN    = 4,
  parameter int unsigned MAX_GREEN    = 16,
  parameter int unsigned YELLOW_TIME  = 3,
  parameter int unsigned ALL_RED_TIME = 1,
  parameter int unsigned STARVE_LIMIT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] lane_counts,
  output logic [7:0]  green_lights,
  output logic [7:0]  yellow_lights,
  output logic [1:0]  phase_dir,
  output logic [1:0]  phase_state,
  output logic        phase_done
);

  localparam int unsigned TMaxGy = (MAX_GREEN > YELLOW_TIME) ? MAX_GREEN : YELLOW_TIME;
  localparam int unsigned TMax   = (TMaxGy > ALL_RED_TIME) ? TMaxGy : ALL_RED_TIME;
  localparam int unsigned TW     = $clog2(TMax + 1);
  localparam int unsigned SW     = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    StRedClear = 2'd0,
    StGreen    = 2'd1,
    StYellow   = 2'd2
  } state_e;

  state_e          r_state, w_state_d;
  logic [TW-1:0]   r_timer, w_timer_d;
  logic [1:0]      r_dir, w_dir_d;
  logic [SW-1:0]   r_starve [4];
  logic [SW-1:0]   w_starve_d [4];
  logic [7:0]      r_green, r_yellow;
  logic            r_done;

  logic [8:0]      w_sum [4];
  logic [8:0]      w_best;
  logic [3:0]      w_demand, w_starved;
  logic [1:0]      w_sel;
  logic            w_grant;
  logic            w_other_demand, w_other_bigger, w_other_starved, w_preempt;
  logic [31:0]     w_t1;

  always_comb begin
    for (int d = 0; d < 4; d++) begin
      w_sum[d]     = {1'b0, lane_counts[16*d +: 8]} + {1'b0, lane_counts[16*d+8 +: 8]};
      w_demand[d]  = |w_sum[d];
      w_starved[d] = (r_starve[d] == SW'(STARVE_LIMIT));
    end
  end

  // Largest sum with ties to the lowest index, overridden by the lowest starved direction.
  always_comb begin
    w_best = w_sum[0];
    w_sel  = 2'd0;
    for (int d = 1; d < 4; d++) begin
      if (w_sum[d] > w_best) begin
        w_best = w_sum[d];
        w_sel  = 2'(d);
      end
    end
    for (int d = 3; d >= 0; d--) begin
      if (w_starved[d] && w_demand[d]) w_sel = 2'(d);
    end
  end

  always_comb begin
    w_other_demand  = 1'b0;
    w_other_bigger  = 1'b0;
    w_other_starved = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (2'(d) != r_dir) begin
        if (w_demand[d]) w_other_demand = 1'b1;
        if (w_sum[d] > w_sum[r_dir]) w_other_bigger = 1'b1;
        if (w_starved[d]) w_other_starved = 1'b1;
      end
    end
    w_preempt = !w_demand[r_dir] || w_other_bigger || w_other_starved;
    w_t1      = 32'(r_timer) + 32'd1;
  end

  always_comb begin
    w_state_d = r_state;
    w_timer_d = r_timer;
    w_dir_d   = r_dir;
    w_grant   = 1'b0;
    unique case (r_state)
      StRedClear: begin
        if (w_t1 >= ALL_RED_TIME && |w_demand) begin
          w_state_d = StGreen;
          w_timer_d = '0;
          w_dir_d   = w_sel;
          w_grant   = 1'b1;
        end else if (r_timer != TW'(TMax)) begin
          w_timer_d = r_timer + 1'b1;
        end
      end
      StGreen: begin
        if ((w_t1 >= MIN_GREEN && w_preempt) || (w_t1 == MAX_GREEN && w_other_demand)) begin
          w_state_d = StYellow;
          w_timer_d = '0;
        end else if (w_t1 == MAX_GREEN) begin
          w_timer_d = '0;
        end else begin
          w_timer_d = r_timer + 1'b1;
        end
      end
      StYellow: begin
        if (w_t1 == YELLOW_TIME) begin
          w_state_d = StRedClear;
          w_timer_d = '0;
        end else begin
          w_timer_d = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_d = StRedClear;
        w_timer_d = '0;
      end
    endcase
  end

  always_comb begin
    for (int d = 0; d < 4; d++) begin
      w_starve_d[d] = r_starve[d];
      if (!w_demand[d]) begin
        w_starve_d[d] = '0;
      end else if (w_grant && w_sel == 2'(d)) begin
        w_starve_d[d] = '0;
      end else if (!(r_state == StGreen && r_dir == 2'(d)) && !w_starved[d]) begin
        w_starve_d[d] = r_starve[d] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StRedClear;
      r_timer  <= '0;
      r_dir    <= 2'd0;
      r_green  <= 8'h00;
      r_yellow <= 8'h00;
      r_done   <= 1'b0;
      for (int d = 0; d < 4; d++) r_starve[d] <= '0;
    end else begin
      r_state  <= w_state_d;
      r_timer  <= w_timer_d;
      r_dir    <= w_dir_d;
      // Light outputs are derived from the next state so they register alongside it.
      r_green  <= (w_state_d == StGreen) ? (8'h03 << {w_dir_d, 1'b0}) : 8'h00;
      r_yellow <= (w_state_d == StYellow) ? (8'h03 << {w_dir_d, 1'b0}) : 8'h00;
      r_done   <= (w_state_d == StYellow) && (32'(w_timer_d) == YELLOW_TIME - 1);
      for (int d = 0; d < 4; d++) r_starve[d] <= w_starve_d[d];
    end
  end

  assign green_lights  = r_green;
  assign yellow_lights = r_yellow;
  assign phase_dir     = r_dir;
  assign phase_state   = r_state;
  assign phase_done    = r_done;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler: table of {lanes, cycles, expected outputs}
// plus hand sequences for starvation and asynchronous reset mid-yellow.
module tb_phase_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] lanes = 64'h0;
  logic [7:0]  green, yellow;
  logic [1:0]  pdir, pstate;
  logic        pdone;

  int n_tests = 0;
  int n_fail  = 0;

  phase_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lane_counts   (lanes),
    .green_lights  (green),
    .yellow_lights (yellow),
    .phase_dir     (pdir),
    .phase_state   (pstate),
    .phase_done    (pdone)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [63:0] lanes;
    int          n;
    logic [7:0]  g;
    logic [7:0]  y;
    logic [1:0]  st;
    logic [1:0]  dir;
    logic        done;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] g_hist [61];
  logic [7:0] y_hist [61];
  int         e_edge;

  initial begin
    // {rst, lanes, cycles, green, yellow, state, dir, done}
    // Idle after reset, then N-only demand resting in green past MAX_GREEN.
    vecs[0]  = '{1'b1, 64'h0,                   0,  8'h00, 8'h00, 2'd0, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 64'h0,                   5,  8'h00, 8'h00, 2'd0, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 64'h0505,                1,  8'h03, 8'h00, 2'd1, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 64'h0505,                16, 8'h03, 8'h00, 2'd1, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 64'h0505,                10, 8'h03, 8'h00, 2'd1, 2'd0, 1'b0};
    // N sum 2, E1=10 arrives in first green cycle: min green, yellow x3, red, E.
    vecs[5]  = '{1'b1, 64'h0101,                1,  8'h03, 8'h00, 2'd1, 2'd0, 1'b0};
    vecs[6]  = '{1'b0, 64'h0A0101,              3,  8'h03, 8'h00, 2'd1, 2'd0, 1'b0};
    vecs[7]  = '{1'b0, 64'h0A0101,              1,  8'h00, 8'h03, 2'd2, 2'd0, 1'b0};
    vecs[8]  = '{1'b0, 64'h0A0101,              1,  8'h00, 8'h03, 2'd2, 2'd0, 1'b0};
    vecs[9]  = '{1'b0, 64'h0A0101,              1,  8'h00, 8'h03, 2'd2, 2'd0, 1'b1};
    vecs[10] = '{1'b0, 64'h0A0101,              1,  8'h00, 8'h00, 2'd0, 2'd0, 1'b0};
    vecs[11] = '{1'b0, 64'h0A0101,              1,  8'h0C, 8'h00, 2'd1, 2'd1, 1'b0};
    // All lanes equal: tie goes to N.
    vecs[12] = '{1'b1, 64'h0303030303030303,    1,  8'h03, 8'h00, 2'd1, 2'd0, 1'b0};
    // W only, demand vanishes at green cycle 6: yellow, red, then idle.
    vecs[13] = '{1'b1, 64'h0009000000000000,    1,  8'hC0, 8'h00, 2'd1, 2'd3, 1'b0};
    vecs[14] = '{1'b0, 64'h0009000000000000,    6,  8'hC0, 8'h00, 2'd1, 2'd3, 1'b0};
    vecs[15] = '{1'b0, 64'h0,                   1,  8'h00, 8'hC0, 2'd2, 2'd3, 1'b0};
    vecs[16] = '{1'b0, 64'h0,                   2,  8'h00, 8'hC0, 2'd2, 2'd3, 1'b1};
    vecs[17] = '{1'b0, 64'h0,                   1,  8'h00, 8'h00, 2'd0, 2'd3, 1'b0};
    vecs[18] = '{1'b0, 64'h0,                   5,  8'h00, 8'h00, 2'd0, 2'd3, 1'b0};

    for (int i = 0; i < 19; i++) begin
      lanes = vecs[i].lanes;
      if (vecs[i].rst) do_reset();
      tick(vecs[i].n);
      check($sformatf("v%0d green", i),  green,            vecs[i].g);
      check($sformatf("v%0d yellow", i), yellow,           vecs[i].y);
      check($sformatf("v%0d state", i),  {6'b0, pstate},   {6'b0, vecs[i].st});
      check($sformatf("v%0d dir", i),    {6'b0, pdir},     {6'b0, vecs[i].dir});
      check($sformatf("v%0d done", i),   {7'b0, pdone},    {7'b0, vecs[i].done});
    end

    // Starvation: N1=200 dominates, E1=1 waits until its counter saturates.
    lanes = 64'h0000_0000_0001_00C8;
    do_reset();
    e_edge = 0;
    for (int k = 1; k <= 60; k++) begin
      tick(1);
      g_hist[k] = green;
      y_hist[k] = yellow;
      if (green == 8'h0C && e_edge == 0) e_edge = k;
    end
    check("starve first N green start", g_hist[1],  8'h03);
    check("starve first N green end",   g_hist[16], 8'h03);
    check("starve first N yellow",      y_hist[17], 8'h03);
    check("starve green off in yellow", g_hist[17], 8'h00);
    check("starve N regrant",           g_hist[21], 8'h03);
    check("starve N regrant last",      g_hist[32], 8'h03);
    check("starve N preempt yellow",    y_hist[33], 8'h03);
    check("starve E grant edge",        8'(e_edge), 8'd37);

    // Asynchronous reset during yellow clears outputs without a clock edge.
    lanes = 64'h0505;
    do_reset();
    tick(1);
    lanes = 64'h0;
    tick(4);
    check("pre-reset yellow", yellow, 8'h03);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst green",  green,            8'h00);
    check("async rst yellow", yellow,           8'h00);
    check("async rst state",  {6'b0, pstate},   8'h00);
    check("async rst done",   {7'b0, pdone},    8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    check("post-reset idle state", {6'b0, pstate}, 8'h00);
    check("post-reset idle green", green,          8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
